wb_trace_serializer: RTL and testbench

//  Sits directly downstream of the dual-issue commit (MEM/WB) register and watches both retirement slots.
//  It serialises up to two register-file writebacks per cycle into the single-entry-per-cycle NSCSCC debug

---
 rtl/wb_trace_serializer_pkg.sv | 35 +++
 rtl/wb_trace_serializer_if.sv | 40 ++++
 rtl/wb_trace_serializer_dual_push_fifo.sv | 50 +++++
 rtl/wb_trace_serializer.sv | 120 ++++++++++++
 tb/tb_wb_trace_serializer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_trace_serializer_pkg.sv
// Shared types and constants for the commit-to-debug-trace serializer.
// Holds the trace entry layout and the slot eligibility rule.
package wb_trace_serializer_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [REG_BUS-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR  = '0;
  localparam logic                    STOP          = 1'b1;
  localparam logic [3:0]              TRACE_WEN_ON  = 4'hF;
  localparam logic [3:0]              TRACE_WEN_OFF = 4'h0;

  typedef struct packed {
    logic [REG_BUS-1:0]      pc;
    logic                    we;
    logic [REG_ADDR_BUS-1:0] wnum;
    logic [REG_BUS-1:0]      wdata;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

  // A held commit output is only counted in its single released cycle.
  function automatic logic slot_eligible(
    input logic                    trace_all,
    input logic                    hold,
    input logic [REG_BUS-1:0]      pc,
    input logic                    we,
    input logic [REG_ADDR_BUS-1:0] waddr
  );
    return (pc != ZERO_WORD) && (hold != STOP) &&
           (trace_all || (we && (waddr != NOP_REG_ADDR)));
  endfunction

endpackage

// File: rtl/wb_trace_serializer_if.sv
// Commit-side retirement slots, ctrl stall request and debug trace port.
// master = commit/ctrl/trace consumer side, slave = the serializer.
interface wb_trace_serializer_if;
  import wb_trace_serializer_pkg::*;

  logic                    wb_hold_i;
  logic [REG_BUS-1:0]      inst_addr_i1;
  logic                    we_i1;
  logic [REG_ADDR_BUS-1:0] waddr_i1;
  logic [REG_BUS-1:0]      wdata_i1;
  logic [REG_BUS-1:0]      inst_addr_i2;
  logic                    we_i2;
  logic [REG_ADDR_BUS-1:0] waddr_i2;
  logic [REG_BUS-1:0]      wdata_i2;
  logic                    stall_req_o;
  logic [REG_BUS-1:0]      debug_wb_pc;
  logic [3:0]              debug_wb_rf_wen;
  logic [REG_ADDR_BUS-1:0] debug_wb_rf_wnum;
  logic [REG_BUS-1:0]      debug_wb_rf_wdata;
  logic                    trace_ovf_o;

  modport master (
    output wb_hold_i,
    output inst_addr_i1, we_i1, waddr_i1, wdata_i1,
    output inst_addr_i2, we_i2, waddr_i2, wdata_i2,
    input  stall_req_o,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  trace_ovf_o
  );

  modport slave (
    input  wb_hold_i,
    input  inst_addr_i1, we_i1, waddr_i1, wdata_i1,
    input  inst_addr_i2, we_i2, waddr_i2, wdata_i2,
    output stall_req_o,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output trace_ovf_o
  );

endinterface

// File: rtl/wb_trace_serializer_dual_push_fifo.sv
// Circular FIFO with two in-order push ports and one pop; head is read combinationally.
// Latency: push visible at head next cycle; no internal backpressure, caller must respect o_count.
module dual_push_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 70
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push0_vld,
  input  logic [WIDTH-1:0]             i_push0_dat,
  input  logic                         i_push1_vld,
  input  logic [WIDTH-1:0]             i_push1_dat,
  input  logic                         i_pop_rdy,
  output logic [WIDTH-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr1_ptr;

  // Port 1 lands right behind port 0 so the pair keeps program order.
  assign w_wr1_ptr = r_wr_ptr + PW'(i_push0_vld);

  always_ff @(posedge clk) begin
    if (i_push0_vld) r_mem[r_wr_ptr] <= i_push0_dat;
    if (i_push1_vld) r_mem[w_wr1_ptr] <= i_push1_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push0_vld) + PW'(i_push1_vld);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop_rdy);
      r_count  <= r_count + CW'(i_push0_vld) + CW'(i_push1_vld) - CW'(i_pop_rdy);
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/wb_trace_serializer.sv
// Serialises up to two commit writebacks per cycle onto the one-per-cycle debug trace port.
// Latency: 1 cycle with empty FIFO (bypass); backpressure via registered stall_req_o at DEPTH-3.
module wb_trace_serializer
  import wb_trace_serializer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TRACE_ALL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_trace_serializer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] STALL_LEVEL = SW'(DEPTH - 3);

  logic          w_elig1;
  logic          w_elig2;
  trace_entry_t  w_ent1;
  trace_entry_t  w_ent2;
  trace_entry_t  w_first;
  logic [1:0]    w_n_enq;

  logic [CW-1:0] w_fifo_count;
  trace_entry_t  w_fifo_head;
  trace_entry_t  w_dbg_next;
  logic          w_pop;
  logic          w_cand0_vld;
  logic          w_cand1_vld;
  trace_entry_t  w_cand0;
  trace_entry_t  w_cand1;
  logic          w_push0;
  logic          w_push1;
  logic          w_drop;
  logic [SW-1:0] w_free;
  logic [SW-1:0] w_total;
  logic [SW-1:0] w_count_next;
  logic          w_stall_next;

  trace_entry_t  r_dbg;
  logic          r_stall;
  logic          r_ovf;

  assign w_elig1 = slot_eligible(TRACE_ALL != 0, bus.wb_hold_i, bus.inst_addr_i1,
                                 bus.we_i1, bus.waddr_i1);
  assign w_elig2 = slot_eligible(TRACE_ALL != 0, bus.wb_hold_i, bus.inst_addr_i2,
                                 bus.we_i2, bus.waddr_i2);

  assign w_ent1 = '{pc: bus.inst_addr_i1, we: bus.we_i1, wnum: bus.waddr_i1, wdata: bus.wdata_i1};
  assign w_ent2 = '{pc: bus.inst_addr_i2, we: bus.we_i2, wnum: bus.waddr_i2, wdata: bus.wdata_i2};

  assign w_n_enq = {1'b0, w_elig1} + {1'b0, w_elig2};
  assign w_first = w_elig1 ? w_ent1 : w_ent2;

  // Oldest pending entry goes to the trace regs; the rest are compacted onto the push ports.
  always_comb begin
    w_dbg_next  = '0;
    w_pop       = 1'b0;
    w_cand0_vld = 1'b0;
    w_cand1_vld = 1'b0;
    w_cand0     = w_first;
    w_cand1     = w_ent2;
    if (w_fifo_count != '0) begin
      w_dbg_next  = w_fifo_head;
      w_pop       = 1'b1;
      w_cand0_vld = (w_n_enq != 2'd0);
      w_cand1_vld = (w_n_enq == 2'd2);
    end else if (w_n_enq != 2'd0) begin
      w_dbg_next  = w_first;
      w_cand0_vld = (w_n_enq == 2'd2);
      w_cand0     = w_ent2;
    end
  end

  // Space after this cycle's pop; only the youngest entries can be refused.
  assign w_free  = SW'(DEPTH) - SW'(w_fifo_count) + SW'(w_pop);
  assign w_push0 = w_cand0_vld && (w_free >= SW'(1));
  assign w_push1 = w_cand1_vld && (w_free >= SW'(2));
  assign w_drop  = (w_cand0_vld && !w_push0) || (w_cand1_vld && !w_push1);

  assign w_total      = SW'(w_fifo_count) + SW'(w_n_enq);
  assign w_count_next = w_total - SW'(w_total != '0);
  assign w_stall_next = (w_count_next >= STALL_LEVEL);

  dual_push_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push0_vld (w_push0),
    .i_push0_dat (w_cand0),
    .i_push1_vld (w_push1),
    .i_push1_dat (w_cand1),
    .i_pop_rdy   (w_pop),
    .o_head_dat  (w_fifo_head),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg   <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_dbg   <= w_dbg_next;
      r_stall <= w_stall_next;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign bus.debug_wb_pc       = r_dbg.pc;
  assign bus.debug_wb_rf_wen   = r_dbg.we ? TRACE_WEN_ON : TRACE_WEN_OFF;
  assign bus.debug_wb_rf_wnum  = r_dbg.wnum;
  assign bus.debug_wb_rf_wdata = r_dbg.wdata;
  assign bus.stall_req_o       = r_stall;
  assign bus.trace_ovf_o       = r_ovf;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Bench for wb_trace_serializer: directed scenarios plus randomized traffic against a queue model.
// Two instances share stimulus: TRACE_ALL=0 (main) and TRACE_ALL=1.
module tb_wb_trace_serializer;
  import wb_trace_serializer_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_trace_serializer_if bus0();
  wb_trace_serializer_if bus1();

  assign bus1.wb_hold_i    = bus0.wb_hold_i;
  assign bus1.inst_addr_i1 = bus0.inst_addr_i1;
  assign bus1.we_i1        = bus0.we_i1;
  assign bus1.waddr_i1     = bus0.waddr_i1;
  assign bus1.wdata_i1     = bus0.wdata_i1;
  assign bus1.inst_addr_i2 = bus0.inst_addr_i2;
  assign bus1.we_i2        = bus0.we_i2;
  assign bus1.waddr_i2     = bus0.waddr_i2;
  assign bus1.wdata_i2     = bus0.wdata_i2;

  wb_trace_serializer #(.DEPTH(DEPTH), .TRACE_ALL(0)) u_dut (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  wb_trace_serializer #(.DEPTH(DEPTH), .TRACE_ALL(1)) u_dut_all (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic [72:0] obs0, obs1;
  assign obs0 = {bus0.debug_wb_pc, bus0.debug_wb_rf_wen, bus0.debug_wb_rf_wnum, bus0.debug_wb_rf_wdata};
  assign obs1 = {bus1.debug_wb_pc, bus1.debug_wb_rf_wen, bus1.debug_wb_rf_wnum, bus1.debug_wb_rf_wdata};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain in-order queue of pending trace entries per instance.
  trace_entry_t q0[$];
  trace_entry_t q1[$];
  trace_entry_t exp0, exp1;
  logic exp_stall0, exp_ovf0, exp_stall1, exp_ovf1;

  function automatic logic [72:0] exp_vec(input trace_entry_t e);
    return {e.pc, (e.we ? 4'hF : 4'h0), e.wnum, e.wdata};
  endfunction

  function automatic bit elig(input bit ta, input logic hold, input logic [31:0] pc,
                              input logic we, input logic [4:0] a);
    return (pc != 0) && !hold && (ta || (we && a != 0));
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete();
    exp0 = '0; exp1 = '0;
    exp_stall0 = 0; exp_ovf0 = 0; exp_stall1 = 0; exp_ovf1 = 0;
  endtask

  task automatic model_edge();
    trace_entry_t s1, s2;
    if (!rst) begin
      model_clear();
      return;
    end
    s1 = '{pc: bus0.inst_addr_i1, we: bus0.we_i1, wnum: bus0.waddr_i1, wdata: bus0.wdata_i1};
    s2 = '{pc: bus0.inst_addr_i2, we: bus0.we_i2, wnum: bus0.waddr_i2, wdata: bus0.wdata_i2};
    if (elig(0, bus0.wb_hold_i, s1.pc, s1.we, s1.wnum)) q0.push_back(s1);
    if (elig(0, bus0.wb_hold_i, s2.pc, s2.we, s2.wnum)) q0.push_back(s2);
    if (elig(1, bus0.wb_hold_i, s1.pc, s1.we, s1.wnum)) q1.push_back(s1);
    if (elig(1, bus0.wb_hold_i, s2.pc, s2.we, s2.wnum)) q1.push_back(s2);
    exp0 = '0;
    if (q0.size() != 0) exp0 = q0.pop_front();
    exp1 = '0;
    if (q1.size() != 0) exp1 = q1.pop_front();
    while (q0.size() > DEPTH) begin void'(q0.pop_back()); exp_ovf0 = 1; end
    while (q1.size() > DEPTH) begin void'(q1.pop_back()); exp_ovf1 = 1; end
    exp_stall0 = (q0.size() >= DEPTH - 3);
    exp_stall1 = (q1.size() >= DEPTH - 3);
  endtask

  task automatic drive(input logic hold,
                       input logic [31:0] pc1, input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [31:0] pc2, input logic we2, input logic [4:0] a2, input logic [31:0] d2);
    bus0.wb_hold_i    = hold;
    bus0.inst_addr_i1 = pc1; bus0.we_i1 = we1; bus0.waddr_i1 = a1; bus0.wdata_i1 = d1;
    bus0.inst_addr_i2 = pc2; bus0.we_i2 = we2; bus0.waddr_i2 = a2; bus0.wdata_i2 = d2;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    bubble();
    #2 rst = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL reset_dbg: got %h want 0", obs0); end
    n_cmp++; if (bus0.stall_req_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus0.stall_req_o); end
    n_cmp++; if (bus0.trace_ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus0.trace_ovf_o); end
    drive(0, 32'hBFC0_0F00, 1, 5'd1, 32'h1, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL reset_held_dbg: got %h want 0", obs0); end
    n_cmp++; if (obs1 !== 73'h0) begin n_err++; $display("FAIL reset_held_dbg_all: got %h want 0", obs1); end
    bubble();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_dual_retire();
    drive(0, 32'hBFC0_0000, 1, 5'd2, 32'h11, 32'hBFC0_0004, 1, 5'd3, 32'h22);
    tick();
    n_cmp++; if (obs0 !== {32'hBFC0_0000, 4'hF, 5'd2, 32'h11}) begin n_err++; $display("FAIL dual_t1: got %h want %h", obs0, {32'hBFC0_0000, 4'hF, 5'd2, 32'h11}); end
    bubble();
    tick();
    n_cmp++; if (obs0 !== {32'hBFC0_0004, 4'hF, 5'd3, 32'h22}) begin n_err++; $display("FAIL dual_t2: got %h want %h", obs0, {32'hBFC0_0004, 4'hF, 5'd3, 32'h22}); end
    tick();
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL dual_t3: got %h want 0", obs0); end
  endtask

  task automatic test_filter();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(0, 32'hBFC0_0008, 1, 5'd0, 32'hA8, 0, 0, 0, 0);
        1: drive(0, 32'hBFC0_000C, 0, 5'd4, 32'hAC, 0, 0, 0, 0);
        2: drive(0, 32'h0, 1, 5'd6, 32'hB0, 0, 0, 0, 0);
        default: bubble();
      endcase
      tick();
      n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL filter_none cyc%0d: got %h want 0", i, obs0); end
      n_cmp++; if (obs1 !== exp_vec(exp1)) begin n_err++; $display("FAIL filter_all cyc%0d: got %h want %h", i, obs1, exp_vec(exp1)); end
    end
    drive(0, 32'hBFC0_0010, 0, 5'd9, 32'h99, 0, 0, 0, 0);
    tick();
    n_cmp++; if (obs1 !== {32'hBFC0_0010, 4'h0, 5'd9, 32'h99}) begin n_err++; $display("FAIL filter_traceall_we0: got %h want %h", obs1, {32'hBFC0_0010, 4'h0, 5'd9, 32'h99}); end
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL filter_we0_main: got %h want 0", obs0); end
    bubble();
    tick();
  endtask

  task automatic test_hold();
    int seen = 0;
    drive(1, 32'hBFC0_0020, 1, 5'd5, 32'h55, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL hold_cyc%0d: got %h want 0", i, obs0); end
    end
    drive(0, 32'hBFC0_0020, 1, 5'd5, 32'h55, 0, 0, 0, 0);
    tick();
    n_cmp++; if (obs0 !== {32'hBFC0_0020, 4'hF, 5'd5, 32'h55}) begin n_err++; $display("FAIL hold_release: got %h want %h", obs0, {32'hBFC0_0020, 4'hF, 5'd5, 32'h55}); end
    bubble();
    for (int i = 0; i < 3; i++) begin
      if (bus0.debug_wb_pc == 32'hBFC0_0020) seen++;
      tick();
    end
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL hold_once: got %0d traces want 1", seen); end
  endtask

  task automatic test_backpressure();
    logic stall_prev = 0, stall_use, saw_stall = 0;
    logic [31:0] pc = 32'hBFC0_1000;
    for (int i = 0; i < 24; i++) begin
      stall_use  = stall_prev;
      stall_prev = bus0.stall_req_o;
      if (stall_use) bubble();
      else begin
        drive(0, pc, 1, 5'(i % 31 + 1), $urandom, pc + 4, 1, 5'((i + 7) % 31 + 1), $urandom);
        pc += 8;
      end
      tick();
      n_cmp++; if (obs0 !== exp_vec(exp0)) begin n_err++; $display("FAIL bp_dbg cyc%0d: got %h want %h", i, obs0, exp_vec(exp0)); end
      n_cmp++; if (bus0.stall_req_o !== exp_stall0) begin n_err++; $display("FAIL bp_stall cyc%0d: got %b want %b", i, bus0.stall_req_o, exp_stall0); end
      n_cmp++; if (bus0.trace_ovf_o !== 1'b0) begin n_err++; $display("FAIL bp_ovf cyc%0d: got %b want 0", i, bus0.trace_ovf_o); end
      if (bus0.stall_req_o) saw_stall = 1;
    end
    n_cmp++; if (saw_stall !== 1'b1) begin n_err++; $display("FAIL bp_stall_seen: got %b want 1", saw_stall); end
    bubble();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (obs0 !== exp_vec(exp0)) begin n_err++; $display("FAIL bp_drain cyc%0d: got %h want %h", i, obs0, exp_vec(exp0)); end
      n_cmp++; if (bus0.stall_req_o !== exp_stall0) begin n_err++; $display("FAIL bp_drain_stall cyc%0d: got %b want %b", i, bus0.stall_req_o, exp_stall0); end
    end
  endtask

  task automatic test_order();
    logic stall_prev = 0, stall_use;
    logic [31:0] pc = 32'hBFC0_2000;
    int n_sent = 0, n_seen = 0;
    for (int i = 0; i < 32; i++) begin
      stall_use  = stall_prev;
      stall_prev = bus0.stall_req_o;
      if (i >= 20 || stall_use) bubble();
      else begin
        case (i % 3)
          0: begin drive(0, pc, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0, 0); n_sent += 1; end
          1: begin drive(0, 0, 0, 0, 0, pc, 1, 5'($urandom_range(1, 31)), $urandom); n_sent += 1; end
          default: begin
            drive(0, pc, 1, 5'($urandom_range(1, 31)), $urandom, pc + 4, 1, 5'($urandom_range(1, 31)), $urandom);
            n_sent += 2;
          end
        endcase
        pc += 8;
      end
      tick();
      if (bus0.debug_wb_pc != 0) n_seen++;
      n_cmp++; if (obs0 !== exp_vec(exp0)) begin n_err++; $display("FAIL order_dbg cyc%0d: got %h want %h", i, obs0, exp_vec(exp0)); end
      n_cmp++; if (bus0.trace_ovf_o !== exp_ovf0) begin n_err++; $display("FAIL order_ovf cyc%0d: got %b want %b", i, bus0.trace_ovf_o, exp_ovf0); end
    end
    n_cmp++; if (n_seen !== n_sent) begin n_err++; $display("FAIL order_count: got %0d traced want %0d", n_seen, n_sent); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] pc = 32'hBFC0_3000;
    for (int i = 0; i < 4; i++) begin
      drive(0, pc, 1, 5'd10, $urandom, pc + 4, 1, 5'd11, $urandom);
      pc += 8;
      tick();
      n_cmp++; if (obs0 !== exp_vec(exp0)) begin n_err++; $display("FAIL mid_fill cyc%0d: got %h want %h", i, obs0, exp_vec(exp0)); end
    end
    #1 rst = 1'b0;
    #1;
    model_clear();
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL mid_rst_dbg: got %h want 0", obs0); end
    n_cmp++; if (bus0.stall_req_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall: got %b want 0", bus0.stall_req_o); end
    bubble();
    tick();
    n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL mid_rst_next: got %h want 0", obs0); end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'hBFC0_0100, 1, 5'd7, 32'h7, 0, 0, 0, 0);
    tick();
    n_cmp++; if (obs0 !== {32'hBFC0_0100, 4'hF, 5'd7, 32'h7}) begin n_err++; $display("FAIL mid_new_entry: got %h want %h", obs0, {32'hBFC0_0100, 4'hF, 5'd7, 32'h7}); end
    bubble();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (obs0 !== 73'h0) begin n_err++; $display("FAIL mid_leftover cyc%0d: got %h want 0", i, obs0); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_dual_retire();
    test_filter();
    test_hold();
    test_backpressure();
    test_order();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
